// File: rtl/mem_wb_stage_pkg.sv
// Shared types, widths and funct3 load/store encodings for the memory/writeback stage.
package mem_wb_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned STRB_W = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Data-memory request payload as driven onto the req/ack port.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_bus_t;

  // Access size implied by funct3; unlisted encodings behave as a word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: f3_size = SZ_B;
      F3_LH, F3_LHU: f3_size = SZ_H;
      F3_LW:         f3_size = SZ_W;
      default:       f3_size = SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Load data alignment: selects the addressed byte/half of the read word and extends it.
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [2:0]        i_funct3,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_rdata[{i_lane, 3'b000} +: 8];
    w_half   = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data_c = i_rdata;
    case (i_funct3)
      F3_LB:   o_data_c = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data_c = {24'd0, w_byte};
      F3_LH:   o_data_c = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data_c = {16'd0, w_half};
      default: o_data_c = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access + writeback stage feeding the register-file write port.
// Optional MISALIGN_CHECK_EN adds misalign_err and suppresses misaligned accesses.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_W,
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned RD_WIDTH   = RD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [RD_WIDTH-1:0]   rd_in,
  input  logic                  regwrite_in,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MISALIGN_CHECK_EN
  output logic                  misalign_err,
`endif
  output logic                  regwrite,
  output logic [RD_WIDTH-1:0]   rd,
  output logic [DATA_WIDTH-1:0] write_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEM,
    ST_WB
  } state_e;

  state_e              r_state, w_state;
  logic                r_ready, w_ready;
  logic                r_mem_req, w_mem_req;
  mem_bus_t            r_bus, w_bus, w_req_bus;
  logic                r_regwrite, w_regwrite;
  logic [RD_W-1:0]     r_rd, w_rd;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [2:0]          r_funct3, w_funct3;
  logic [1:0]          r_lane, w_lane;
  logic [RD_W-1:0]     r_pend_rd, w_pend_rd;
  logic                r_pend_rw, w_pend_rw;
  logic [DATA_W-1:0]   w_load_data;
  logic                w_accept;
  logic                w_misaligned;

  assign w_accept = (r_state == ST_IDLE) && valid_in && r_ready;

`ifdef MISALIGN_CHECK_EN
  logic r_misalign_err, w_misalign_err;

  assign w_misaligned = ((f3_size(funct3) == SZ_H) && alu_result[0]) ||
                        ((f3_size(funct3) == SZ_W) && (alu_result[1:0] != 2'b00));
  assign w_misalign_err = w_accept && (is_load || is_store) && w_misaligned;
  assign misalign_err   = r_misalign_err;
`else
  assign w_misaligned = 1'b0;
`endif

  // Request payload for the instruction being offered this cycle.
  always_comb begin
    w_req_bus.we    = is_store;
    w_req_bus.addr  = {alu_result[ADDR_W-1:2], 2'b00};
    w_req_bus.wdata = store_data;
    w_req_bus.wstrb = '0;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          w_req_bus.wdata = {4{store_data[7:0]}};
          w_req_bus.wstrb = STRB_W'(4'b0001 << alu_result[1:0]);
        end
        F3_SH: begin
          w_req_bus.wdata = {2{store_data[15:0]}};
          w_req_bus.wstrb = STRB_W'(4'b0011 << {alu_result[1], 1'b0});
        end
        F3_SW:   w_req_bus.wstrb = '1;
        default: w_req_bus.wstrb = '1;
      endcase
    end
  end

  mem_wb_stage_load_align u_load_align (
    .i_funct3 (r_funct3),
    .i_lane   (r_lane),
    .i_rdata  (mem_rdata),
    .o_data_c (w_load_data)
  );

  always_comb begin
    w_state    = r_state;
    w_ready    = r_ready;
    w_mem_req  = r_mem_req;
    w_bus      = r_bus;
    w_regwrite = 1'b0;
    w_rd       = r_rd;
    w_wdata    = r_wdata;
    w_funct3   = r_funct3;
    w_lane     = r_lane;
    w_pend_rd  = r_pend_rd;
    w_pend_rw  = r_pend_rw;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_load || is_store) begin
            if (!w_misaligned) begin
              w_state   = ST_MEM;
              w_ready   = 1'b0;
              w_mem_req = 1'b1;
              w_bus     = w_req_bus;
              w_funct3  = funct3;
              w_lane    = alu_result[1:0];
              w_pend_rd = rd_in;
              w_pend_rw = regwrite_in;
            end
          end else begin
            w_regwrite = regwrite_in && (rd_in != '0);
            if (w_regwrite) begin
              w_rd    = rd_in;
              w_wdata = alu_result;
            end
          end
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          w_mem_req = 1'b0;
          if (r_bus.we) begin
            w_state = ST_IDLE;
            w_ready = 1'b1;
          end else begin
            // Writeback pulse lands in the WB cycle, one after the ack.
            w_state    = ST_WB;
            w_regwrite = r_pend_rw && (r_pend_rd != '0);
            if (w_regwrite) begin
              w_rd    = r_pend_rd;
              w_wdata = w_load_data;
            end
          end
        end
      end
      ST_WB: begin
        w_state = ST_IDLE;
        w_ready = 1'b1;
      end
      default: begin
        w_state = ST_IDLE;
        w_ready = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ready    <= 1'b1;
      r_mem_req  <= 1'b0;
      r_bus      <= '0;
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_lane     <= '0;
      r_pend_rd  <= '0;
      r_pend_rw  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_ready    <= w_ready;
      r_mem_req  <= w_mem_req;
      r_bus      <= w_bus;
      r_regwrite <= w_regwrite;
      r_rd       <= w_rd;
      r_wdata    <= w_wdata;
      r_funct3   <= w_funct3;
      r_lane     <= w_lane;
      r_pend_rd  <= w_pend_rd;
      r_pend_rw  <= w_pend_rw;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) r_misalign_err <= 1'b0;
    else     r_misalign_err <= w_misalign_err;
  end
`endif

  assign ready_in   = r_ready;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_bus.we;
  assign mem_addr   = r_bus.addr;
  assign mem_wdata  = r_bus.wdata;
  assign mem_wstrb  = r_bus.wstrb;
  assign regwrite   = r_regwrite;
  assign rd         = r_rd;
  assign write_data = r_wdata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage; honours MISALIGN_CHECK_EN when defined.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic        regwrite_in;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        regwrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .is_load     (is_load),
    .is_store    (is_store),
    .funct3      (funct3),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .rd_in       (rd_in),
    .regwrite_in (regwrite_in),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
`ifdef MISALIGN_CHECK_EN
    .misalign_err(misalign_err),
`endif
    .regwrite    (regwrite),
    .rd          (rd),
    .write_data  (write_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offers one instruction for a single cycle; returns just after the accepting edge.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd,
                       input logic [4:0] rdi, input logic rw);
    valid_in    = 1'b1;
    is_load     = ld;
    is_store    = st;
    funct3      = f3;
    alu_result  = alu;
    store_data  = sd;
    rd_in       = rdi;
    regwrite_in = rw;
    tick();
    valid_in    = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
  endtask

  // Completes the outstanding access with a single-cycle ack carrying rdata.
  task automatic ack(input logic [31:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    alu_result = '0; store_data = '0; rd_in = '0; regwrite_in = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_ready", 32'(ready_in), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_wdata", write_data, 32'h0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
    rst = 1'b0;
    tick();

    // ALU result writeback, one-cycle latency
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    chk("add_regwrite", 32'(regwrite), 32'd1);
    chk("add_rd", 32'(rd), 32'd5);
    chk("add_wdata", write_data, 32'h0000_1234);
    chk("add_ready", 32'(ready_in), 32'd1);
    tick();
    chk("add_pulse_end", 32'(regwrite), 32'd0);

    // rd=0 suppresses the write
    issue(1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1);
    chk("add_rd0", 32'(regwrite), 32'd0);

    // LB at lane 3 with three wait cycles
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    chk("lb_addr", mem_addr, 32'h0000_0100);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_ready", 32'(ready_in), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("lb_req_held", 32'(mem_req), 32'd1);
      chk("lb_no_wb", 32'(regwrite), 32'd0);
      tick();
    end
    chk("lb_req_ack_cycle", 32'(mem_req), 32'd1);
    ack(32'h80FF_FFFF);
    chk("lb_req_drop", 32'(mem_req), 32'd0);
    chk("lb_regwrite", 32'(regwrite), 32'd1);
    chk("lb_rd", 32'(rd), 32'd7);
    chk("lb_wdata", write_data, 32'hFFFF_FF80);
    tick();
    chk("lb_pulse_end", 32'(regwrite), 32'd0);
    chk("lb_ready_back", 32'(ready_in), 32'd1);

    // LHU / LH upper half
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    ack(32'hBEEF_0000);
    chk("lhu_wdata", write_data, 32'h0000_BEEF);
    tick();
    issue(1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd9, 1'b1);
    ack(32'hBEEF_0000);
    chk("lh_wdata", write_data, 32'hFFFF_BEEF);
    tick();

    // LW into x0: no writeback
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd0, 1'b1);
    ack(32'h1234_5678);
    chk("lw_rd0", 32'(regwrite), 32'd0);
    tick();

    // SB lane 1, held across a wait cycle
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 1'b0);
    chk("sb_req", 32'(mem_req), 32'd1);
    chk("sb_we", 32'(mem_we), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_0200);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    tick();
    chk("sb_wstrb_held", 32'(mem_wstrb), 32'h2);
    ack(32'h0);
    chk("sb_req_drop", 32'(mem_req), 32'd0);
    chk("sb_no_wb", 32'(regwrite), 32'd0);
    chk("sb_ready", 32'(ready_in), 32'd1);

    // SH upper half and SW
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_CDEF, 5'd0, 1'b0);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
    ack(32'h0);
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 5'd0, 1'b0);
    chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("sw_addr", mem_addr, 32'h0000_0204);
    ack(32'h0);

`ifndef MISALIGN_CHECK_EN
    // Halfword straddling the word boundary keeps the upper-half strobes
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0000_5566, 5'd0, 1'b0);
    chk("sh_cross_wstrb", 32'(mem_wstrb), 32'hC);
    ack(32'h0);
`endif

    // Reset mid-access drops the request and abandons the load
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd3, 1'b1);
    chk("rstmem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("rstmem_req_drop", 32'(mem_req), 32'd0);
    chk("rstmem_ready", 32'(ready_in), 32'd1);
    rst = 1'b0;
    tick();
    chk("rstmem_no_wb", 32'(regwrite), 32'd0);

    // Stray ack while idle has no effect
    ack(32'hFFFF_FFFF);
    chk("idle_ack_req", 32'(mem_req), 32'd0);
    chk("idle_ack_wb", 32'(regwrite), 32'd0);
    chk("idle_ack_ready", 32'(ready_in), 32'd1);

`ifdef MISALIGN_CHECK_EN
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd4, 1'b1);
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_ready", 32'(ready_in), 32'd1);
    tick();
    chk("mis_err_end", 32'(misalign_err), 32'd0);
    chk("mis_req_after", 32'(mem_req), 32'd0);
    chk("mis_no_wb", 32'(regwrite), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
